// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader: FSM state
// encoding, frame marker and word geometry (shared with the UART receiver
// and the instruction memory).
package imem_loader_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_LO = 3'd1;
   localparam logic [2:0] ST_LEN_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;
   localparam logic [2:0] ST_CHK    = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;
   localparam logic [2:0] ST_ERR    = 3'd7;

   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
   localparam int         BYTES_PER_WORD = 4;

   // True while a frame is in flight (from after SYNC up to the checksum byte).
   function automatic logic frame_active(input logic [2:0] st);
      return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA) ||
             (st == ST_WRITE)  || (st == ST_CHK);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status signals of the
// loader. The master side is the loader itself; the slave side is the
// surrounding system (serial front end, memory, core reset logic).
interface imem_loader_if #(
   parameter int ADDRESS_WIDTH = 14,
   parameter int DATA_WIDTH    = 32
);
   logic                     in_valid;
   logic [7:0]               in_data;
   logic                     in_ready;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic                     cpu_hold;
   logic                     done;
   logic                     err;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: frames an incoming byte stream
// (SYNC, LEN_LO, LEN_HI, 4*N data bytes, XOR checksum), packs bytes
// little-endian into words and issues one-cycle writes. Holds the core in
// reset while a frame is being loaded.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDRESS_WIDTH = 14,
   parameter int         DATA_WIDTH    = 32,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.master bus
);

   // Largest legal word count: the whole memory.
   localparam logic [32:0] MAX_WORDS = 33'(1) << ADDRESS_WIDTH;
   localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   logic [2:0]               state_q, state_d;
   logic [15:0]              len_q, len_d;
   logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
   logic [1:0]               cnt_q, cnt_d;
   logic [7:0]               chk_q, chk_d;
   logic [DATA_WIDTH-1:0]    word_q, word_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

   logic        in_ready;
   logic        accept;
   logic [15:0] len_new;

   assign in_ready = (state_q != ST_WRITE);
   assign accept   = bus.in_valid && in_ready;
   assign len_new  = {bus.in_data, len_q[7:0]};

   // Next-state and datapath update for the framing FSM.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      chk_d   = chk_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            // Non-sync bytes are consumed and dropped.
            if (accept && (bus.in_data == SYNC_BYTE)) begin
               state_d = ST_LEN_LO;
               len_d   = '0;
               idx_d   = '0;
               cnt_d   = '0;
               chk_d   = '0;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = bus.in_data;
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = bus.in_data;
               cnt_d       = '0;
               if (33'(len_new) > MAX_WORDS) begin
                  state_d = ST_ERR;
               end else if (len_new == 16'd0) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               // Shift in from the top so byte 0 ends up in the LSBs.
               word_d = {bus.in_data, word_q[DATA_WIDTH-1:8]};
               chk_d  = chk_q ^ bus.in_data;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == LAST_BYTE) begin
                  state_d = ST_WRITE;
                  addr_d  = idx_q;
                  wdata_d = word_d;
               end
            end
         end
         ST_WRITE: begin
            // Index stops at the last word, so it cannot wrap when N fills memory.
            if ((33'(idx_q) + 33'd1) == 33'(len_q)) begin
               state_d = ST_CHK;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_DATA;
            end
         end
         ST_CHK: begin
            if (accept) begin
               state_d = (bus.in_data == chk_q) ? ST_DONE : ST_ERR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         chk_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         chk_q   <= chk_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_we    = (state_q == ST_WRITE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_hold  = frame_active(state_q);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum error, length
// bound, input gaps and mid-frame reset.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst = 1'b0;

   imem_loader_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) bus ();

   imem_loader #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32), .SYNC_BYTE(8'hA5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int viol     = 0;

   logic [13:0] wa[$];
   logic [31:0] wd[$];

   // Write capture plus continuous protocol checks.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
         end
         if (bus.in_ready === bus.mem_we) viol++;
         if (bus.done === 1'b1 && bus.err === 1'b1) viol++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the byte was consumed.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   logic [7:0] frame [12] = '{8'hA5, 8'h02, 8'h00,
                              8'h93, 8'h00, 8'h50, 8'h00,
                              8'h13, 8'h01, 8'h10, 8'h00,
                              8'hC1};

   task automatic send_frame(input logic [7:0] chkb, input bit gaps);
      for (int i = 0; i < 12; i++) begin
         if (gaps) idle($urandom_range(0, 3));
         send_byte((i == 11) ? chkb : frame[i]);
      end
   endtask

   task automatic check_two_writes(input string tag, input int base);
      chk({tag, "_nwr"}, 64'(wa.size()), 64'(base + 2));
      if (wa.size() >= base + 2) begin
         chk({tag, "_a0"}, 64'(wa[base]),     64'd0);
         chk({tag, "_d0"}, 64'(wd[base]),     64'h00500093);
         chk({tag, "_a1"}, 64'(wa[base + 1]), 64'd1);
         chk({tag, "_d1"}, 64'(wd[base + 1]), 64'h00100113);
      end
   endtask

   int base;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // 1: asynchronous reset, checked before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready),  64'd1);
      chk("rst_mem_we",   64'(bus.mem_we),    64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr),  64'd0);
      chk("rst_wdata",    64'(bus.mem_wdata), 64'd0);
      chk("rst_status",   64'({bus.cpu_hold, bus.done, bus.err}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // 2: two-word frame, good checksum
      base = wa.size();
      send_byte(8'hA5);
      chk("t2_hold_after_sync", 64'(bus.cpu_hold), 64'd1);
      for (int i = 1; i < 11; i++) send_byte(frame[i]);
      chk("t2_hold_before_chk", 64'(bus.cpu_hold), 64'd1);
      send_byte(8'hC1);
      idle(2);
      check_two_writes("t2", base);
      chk("t2_status", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b010);
      chk("t2_addr_hold",  64'(bus.mem_addr),  64'd1);
      chk("t2_wdata_hold", 64'(bus.mem_wdata), 64'h00100113);

      // 3: bad checksum, writes still happen
      base = wa.size();
      send_frame(8'hC0, 1'b0);
      idle(2);
      check_two_writes("t3", base);
      chk("t3_status", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b001);

      // 4: length over memory size, then empty frame
      base = wa.size();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h40);
      idle(2);
      chk("t4_status_big", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b001);
      chk("t4_no_write",   64'(wa.size()), 64'(base));
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      idle(2);
      chk("t4_status_empty", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b010);

      // 4b: N equal to memory depth is accepted
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h40);
      idle(2);
      chk("t4_status_max", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // 5: random gaps between bytes
      base = wa.size();
      send_frame(8'hC1, 1'b1);
      idle(2);
      check_two_writes("t5", base);
      chk("t5_status", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b010);

      // 6: reset after six data bytes, then leading junk and full frame
      base = wa.size();
      for (int i = 0; i < 9; i++) send_byte(frame[i]);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_status", 64'({bus.in_ready, bus.cpu_hold, bus.done, bus.err, bus.mem_we}), 64'b10000);
      chk("t6_rst_addr",   64'(bus.mem_addr), 64'd0);
      chk("t6_partial_wr", 64'(wa.size()), 64'(base + 1));
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      base = wa.size();
      send_byte(8'h00);
      send_byte(8'h7E);
      chk("t6_junk_ignored", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b000);
      send_frame(8'hC1, 1'b0);
      idle(2);
      check_two_writes("t6", base);
      chk("t6_status", 64'({bus.cpu_hold, bus.done, bus.err}), 64'b010);

      chk("protocol_violations", 64'(viol), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
